// File: rtl/trng_bit_collector_if.sv
// Collector-to-downstream bus: packed word, its valid pulses, block status and round-end handshakes.
// Latency: n/a (wires only).
// Backpressure: none; the downstream ends a round with round_done or ehr_read.
interface trng_bit_collector_if;
    logic [15:0] data_in16bit;
    logic        valid_16bit;
    logic        collector_valid;
    logic        accum_enough_bits;
    logic [3:0]  collect_words_cnt;
    logic        round_done;
    logic        ehr_read;

    modport master (
        output data_in16bit, valid_16bit, collector_valid, accum_enough_bits, collect_words_cnt,
        input  round_done, ehr_read
    );

    modport slave (
        input  data_in16bit, valid_16bit, collector_valid, accum_enough_bits, collect_words_cnt,
        output round_done, ehr_read
    );
endinterface

// File: rtl/trng_bit_collector.sv
// Samples rnd_bit every P cycles, packs 16 samples per word and counts EHR_WORDS words per block.
// Latency: first word 16*P cycles after COLLECT entry, then one word every 16*P cycles.
// Backpressure: a full block pauses sampling until round_done (or ehr_read when bypassed).
module trng_bit_collector #(
    parameter int SAMPLE_CNT_W = 16,
    parameter int EHR_WORDS    = 12,
    parameter int MIN_SAMPLE   = 2
) (
    input  logic                    rng_clk,
    input  logic                    rst_n,
    input  logic                    rnd_src_en,
    input  logic                    rst_trng_logic,
    input  logic                    rnd_bit,
    input  logic [SAMPLE_CNT_W-1:0] sample_cnt,
    input  logic                    auto_correlate_bypass,
    trng_bit_collector_if.master    bus
);

    localparam logic [SAMPLE_CNT_W-1:0] MIN_P     = SAMPLE_CNT_W'(MIN_SAMPLE);
    localparam logic [SAMPLE_CNT_W-1:0] ONE_P     = SAMPLE_CNT_W'(1);
    localparam logic [3:0]              LAST_WORD = 4'(EHR_WORDS - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_FULL    = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_next_state;
    logic [SAMPLE_CNT_W-1:0] r_period;
    logic [SAMPLE_CNT_W-1:0] r_sample_cnt;
    logic [3:0]              r_bit_cnt;
    logic [15:0]             r_shift;
    logic [15:0]             r_data;
    logic                    r_valid;
    logic                    r_accum;
    logic [3:0]              r_words;

    logic [SAMPLE_CNT_W-1:0] w_period;
    logic                    w_sample_hit;
    logic                    w_word_done;
    logic                    w_round_end;
    logic [15:0]             w_shift_nxt;

    assign w_period     = (sample_cnt < MIN_P) ? MIN_P : sample_cnt;
    assign w_sample_hit = (r_state == S_COLLECT) && (r_sample_cnt == (r_period - ONE_P));
    assign w_word_done  = w_sample_hit && (r_bit_cnt == 4'd15);
    assign w_round_end  = auto_correlate_bypass ? bus.ehr_read : bus.round_done;
    assign w_shift_nxt  = {rnd_bit, r_shift[15:1]};

    always_comb begin
        w_next_state = r_state;
        if (!rnd_src_en) begin
            w_next_state = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:    w_next_state = S_COLLECT;
                S_COLLECT: if (w_word_done && (r_words == LAST_WORD)) w_next_state = S_FULL;
                S_FULL:    if (w_round_end) w_next_state = S_COLLECT;
                default:   w_next_state = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge rng_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else if (rst_trng_logic) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge rng_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_period     <= MIN_P;
            r_sample_cnt <= '0;
            r_bit_cnt    <= '0;
            r_shift      <= '0;
            r_data       <= '0;
            r_valid      <= 1'b0;
            r_accum      <= 1'b0;
            r_words      <= '0;
        end else if (rst_trng_logic) begin
            r_period     <= MIN_P;
            r_sample_cnt <= '0;
            r_bit_cnt    <= '0;
            r_shift      <= '0;
            r_data       <= '0;
            r_valid      <= 1'b0;
            r_accum      <= 1'b0;
            r_words      <= '0;
        end else if (!rnd_src_en) begin
            // Partial word is dropped; last word and block status stay visible.
            r_sample_cnt <= '0;
            r_bit_cnt    <= '0;
            r_shift      <= '0;
            r_valid      <= 1'b0;
            r_words      <= '0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_period     <= w_period;
                    r_accum      <= 1'b0;
                    r_sample_cnt <= '0;
                    r_bit_cnt    <= '0;
                end
                S_COLLECT: begin
                    if (w_sample_hit) begin
                        r_sample_cnt <= '0;
                        r_shift      <= w_shift_nxt;
                        r_bit_cnt    <= r_bit_cnt + 4'd1;
                    end else begin
                        r_sample_cnt <= r_sample_cnt + ONE_P;
                    end
                    if (w_word_done) begin
                        r_data  <= w_shift_nxt;
                        r_valid <= 1'b1;
                        r_words <= r_words + 4'd1;
                        if (r_words == LAST_WORD) r_accum <= 1'b1;
                    end
                end
                S_FULL: begin
                    r_sample_cnt <= '0;
                    r_bit_cnt    <= '0;
                    if (w_round_end) begin
                        r_words <= '0;
                        r_accum <= 1'b0;
                    end
                end
                default: begin
                    r_sample_cnt <= '0;
                    r_bit_cnt    <= '0;
                end
            endcase
        end
    end

    assign bus.data_in16bit      = r_data;
    assign bus.valid_16bit       = r_valid;
    assign bus.collector_valid   = r_valid;
    assign bus.accum_enough_bits = r_accum;
    assign bus.collect_words_cnt = r_words;

endmodule

// File: tb/tb_trng_bit_collector.sv
// Directed bench: drives sample patterns, queues expected words and checks each valid pulse.
module tb_trng_bit_collector;

    logic        rng_clk = 1'b0;
    logic        rst_n;
    logic        rnd_src_en;
    logic        rst_trng_logic;
    logic        rnd_bit;
    logic [15:0] sample_cnt;
    logic        auto_correlate_bypass;

    int          n_vec = 0;
    int          n_err = 0;
    logic [15:0] exp_q[$];
    logic [15:0] last_word;

    trng_bit_collector_if bus ();

    trng_bit_collector #(
        .SAMPLE_CNT_W(16),
        .EHR_WORDS   (12),
        .MIN_SAMPLE  (2)
    ) dut (
        .rng_clk              (rng_clk),
        .rst_n                (rst_n),
        .rnd_src_en           (rnd_src_en),
        .rst_trng_logic       (rst_trng_logic),
        .rnd_bit              (rnd_bit),
        .sample_cnt           (sample_cnt),
        .auto_correlate_bypass(auto_correlate_bypass),
        .bus                  (bus)
    );

    always #5 rng_clk = ~rng_clk;

    task automatic tick();
        @(posedge rng_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one word's samples; valid must appear only on the 16*p-th edge.
    task automatic collect_word(input logic [15:0] pat, input int p);
        bit          seen_early;
        bit          seen_last;
        bit          cv_last;
        logic [15:0] got;
        logic [15:0] exp_w;
        seen_early = 1'b0;
        seen_last  = 1'b0;
        cv_last    = 1'b0;
        got        = '0;
        exp_q.push_back(pat);
        for (int k = 0; k < 16 * p; k++) begin
            rnd_bit = pat[k / p];
            tick();
            if (bus.valid_16bit === 1'b1) begin
                if (k == 16 * p - 1) begin
                    seen_last = 1'b1;
                    cv_last   = (bus.collector_valid === 1'b1);
                    got       = bus.data_in16bit;
                end else begin
                    seen_early = 1'b1;
                end
            end
        end
        exp_w = exp_q.pop_front();
        chk("valid_timing", {30'd0, seen_early, seen_last}, 32'd1);
        if (seen_last) begin
            chk("word_data", {16'd0, got}, {16'd0, exp_w});
            chk("collector_valid", {31'd0, cv_last}, 32'd1);
        end
        last_word = pat;
    endtask

    // Run n cycles of random bits; no valid pulse may appear.
    task automatic quiet(input int n, input string tag);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < n; k++) begin
            rnd_bit = 1'($urandom);
            tick();
            if (bus.valid_16bit !== 1'b0) seen = 1'b1;
        end
        chk(tag, {31'd0, seen}, 32'd0);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_data"},  {16'd0, bus.data_in16bit}, 32'd0);
        chk({tag, "_valid"}, {31'd0, bus.valid_16bit}, 32'd0);
        chk({tag, "_cv"},    {31'd0, bus.collector_valid}, 32'd0);
        chk({tag, "_accum"}, {31'd0, bus.accum_enough_bits}, 32'd0);
        chk({tag, "_cnt"},   {28'd0, bus.collect_words_cnt}, 32'd0);
    endtask

    task automatic pulse_round_done();
        bus.round_done = 1'b1;
        tick();
        bus.round_done = 1'b0;
    endtask

    task automatic pulse_ehr_read();
        bus.ehr_read = 1'b1;
        tick();
        bus.ehr_read = 1'b0;
    endtask

    initial begin
        rst_n                 = 1'b0;
        rnd_src_en            = 1'b0;
        rst_trng_logic        = 1'b0;
        rnd_bit               = 1'b0;
        sample_cnt            = 16'd2;
        auto_correlate_bypass = 1'b0;
        bus.round_done        = 1'b0;
        bus.ehr_read          = 1'b0;
        last_word             = '0;
        repeat (3) tick();
        chk_zero("reset");
        rst_n = 1'b1;
        tick();

        // P=2, reference pattern 1,0,1,1,0,0,0,0,1,1,1,1,0,0,0,0
        rnd_src_en = 1'b1;
        tick();
        collect_word(16'h0F0D, 2);
        chk("cnt_after_first", {28'd0, bus.collect_words_cnt}, 32'd1);
        chk("accum_after_first", {31'd0, bus.accum_enough_bits}, 32'd0);

        rnd_src_en = 1'b0;
        tick();
        chk("idle_cnt_clear", {28'd0, bus.collect_words_cnt}, 32'd0);
        chk("idle_data_hold", {16'd0, bus.data_in16bit}, 32'h0F0D);

        // sample_cnt=0 is clamped to the minimum period of 2
        sample_cnt = 16'd0;
        rnd_src_en = 1'b1;
        tick();
        collect_word(16'hA5C3, 2);

        // P=5: one word every 80 cycles
        rnd_src_en = 1'b0;
        tick();
        sample_cnt = 16'd5;
        rnd_src_en = 1'b1;
        tick();
        collect_word(16'h1234, 5);
        collect_word(16'hFEDC, 5);
        chk("cnt_p5", {28'd0, bus.collect_words_cnt}, 32'd2);

        // Full block with autocorrelation active
        rnd_src_en = 1'b0;
        tick();
        sample_cnt = 16'd2;
        rnd_src_en = 1'b1;
        tick();
        for (int i = 0; i < 12; i++) begin
            collect_word(16'($urandom), 2);
            chk("block_cnt", {28'd0, bus.collect_words_cnt}, 32'(i + 1));
            chk("block_accum", {31'd0, bus.accum_enough_bits}, {31'd0, (i == 11)});
        end
        quiet(64, "full_no_valid");
        chk("full_accum_hold", {31'd0, bus.accum_enough_bits}, 32'd1);
        pulse_ehr_read();
        quiet(40, "ehr_read_ignored");
        chk("ehr_ignored_cnt", {28'd0, bus.collect_words_cnt}, 32'd12);
        pulse_round_done();
        chk("round_done_accum", {31'd0, bus.accum_enough_bits}, 32'd0);
        chk("round_done_cnt", {28'd0, bus.collect_words_cnt}, 32'd0);
        collect_word(16'h5A5A, 2);
        chk("restart_cnt", {28'd0, bus.collect_words_cnt}, 32'd1);

        // Bypass mode: round_done ignored, ehr_read ends the round
        for (int i = 1; i < 12; i++) collect_word(16'($urandom), 2);
        chk("block2_accum", {31'd0, bus.accum_enough_bits}, 32'd1);
        auto_correlate_bypass = 1'b1;
        pulse_round_done();
        quiet(40, "bypass_rd_ignored");
        chk("bypass_accum_hold", {31'd0, bus.accum_enough_bits}, 32'd1);
        pulse_ehr_read();
        chk("bypass_accum_clr", {31'd0, bus.accum_enough_bits}, 32'd0);
        chk("bypass_cnt_clr", {28'd0, bus.collect_words_cnt}, 32'd0);
        collect_word(16'hC001, 2);
        chk("bypass_restart_cnt", {28'd0, bus.collect_words_cnt}, 32'd1);
        auto_correlate_bypass = 1'b0;

        // Soft reset at word 5, bit 9
        for (int i = 1; i < 4; i++) collect_word(16'($urandom), 2);
        chk("pre_soft_cnt", {28'd0, bus.collect_words_cnt}, 32'd4);
        quiet(18, "partial_word5");
        rst_trng_logic = 1'b1;
        tick();
        rst_trng_logic = 1'b0;
        chk_zero("soft_rst");
        tick();
        collect_word(16'h8001, 2);
        chk("soft_restart_cnt", {28'd0, bus.collect_words_cnt}, 32'd1);

        // Source disabled mid word 3
        collect_word(16'h7E3C, 2);
        quiet(20, "partial_word3");
        rnd_src_en = 1'b0;
        tick();
        chk("drop_cnt", {28'd0, bus.collect_words_cnt}, 32'd0);
        chk("drop_data_hold", {16'd0, bus.data_in16bit}, {16'd0, last_word});
        quiet(30, "drop_no_valid");
        rnd_src_en = 1'b1;
        tick();
        collect_word(16'h0FF0, 2);
        chk("reenable_cnt", {28'd0, bus.collect_words_cnt}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
